// File: rtl/axi_burst_mem_slave.sv
// AXI4-full slave memory model: concurrent INCR read/write bursts with byte
// strobes, programmable read latency, optional per-beat stall pattern and a
// sticky burst-length protocol error flag.
module axi_burst_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 4096,
    parameter int RD_LATENCY = 2,
    parameter int STALL_EN   = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                    s_axi_rlast,
    input  logic [7:0]              stall_mask_i,
    output logic                    proto_err_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    // Latency 0 and 1 both present beat 0 right after the AR handshake edge.
    localparam bit LOAD_ON_AR = (RD_LATENCY <= 1);
    localparam logic [3:0] LAT_INIT = (RD_LATENCY >= 2) ? 4'(RD_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;

    // A beat is stalled for one cycle when its bit in the mask is set.
    function automatic logic beat_stalled(input logic [7:0] mask, input logic [7:0] beat);
        return (STALL_EN != 0) && mask[beat[2:0]];
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    // ---------------- write channel ----------------
    w_state_t             w_state_r, w_state_nxt_s;
    logic [IDX_W-1:0]     w_idx_r;
    logic [7:0]           w_len_r, w_beat_r;
    logic                 awready_r, wready_r, bvalid_r, proto_err_r;
    logic                 wready_nxt_s, w_err_s;
    logic                 aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s;
    logic [IDX_W-1:0]     aw_idx_s;

    assign aw_hs_s       = s_axi_awvalid && awready_r;
    assign w_hs_s        = s_axi_wvalid && wready_r;
    assign b_hs_s        = bvalid_r && s_axi_bready;
    assign w_last_beat_s = (w_beat_r == w_len_r);
    assign aw_idx_s      = s_axi_awaddr[OFF_W +: IDX_W];

    // Write FSM next state, next wready and protocol-error detection.
    always_comb begin
        w_state_nxt_s = w_state_r;
        wready_nxt_s  = 1'b0;
        w_err_s       = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) begin
                    w_state_nxt_s = W_DATA;
                    wready_nxt_s  = !beat_stalled(stall_mask_i, 8'd0);
                end else begin
                    w_state_nxt_s = W_IDLE;
                end
            end
            W_DATA: begin
                if (w_hs_s) begin
                    w_err_s = (s_axi_wlast != w_last_beat_s);
                    if (w_last_beat_s || s_axi_wlast) begin
                        w_state_nxt_s = W_RESP;
                    end else begin
                        w_state_nxt_s = W_DATA;
                        wready_nxt_s  = !beat_stalled(stall_mask_i, w_beat_r + 8'd1);
                    end
                end else begin
                    // Either idling with ready high or ending a one-cycle bubble.
                    wready_nxt_s = 1'b1;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    w_state_nxt_s = W_IDLE;
                end else begin
                    w_state_nxt_s = W_RESP;
                end
            end
            default: begin
                w_state_nxt_s = W_IDLE;
            end
        endcase
    end

    // Write FSM state, registered handshake outputs and burst bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_r   <= W_IDLE;
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            proto_err_r <= 1'b0;
            w_idx_r     <= '0;
            w_len_r     <= 8'd0;
            w_beat_r    <= 8'd0;
        end else begin
            w_state_r <= w_state_nxt_s;
            awready_r <= (w_state_nxt_s == W_IDLE);
            wready_r  <= wready_nxt_s;
            bvalid_r  <= (w_state_nxt_s == W_RESP);
            if (w_err_s) begin
                proto_err_r <= 1'b1;
            end
            if (aw_hs_s) begin
                w_idx_r  <= aw_idx_s;
                w_len_r  <= s_axi_awlen;
                w_beat_r <= 8'd0;
            end else if (w_hs_s) begin
                w_idx_r  <= w_idx_r + IDX_W'(1);
                w_beat_r <= w_beat_r + 8'd1;
            end
        end
    end

    // Byte-enabled memory write; the array is never cleared by reset.
    always_ff @(posedge clk) begin
        if (w_hs_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_r[w_idx_r][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t             r_state_r, r_state_nxt_s;
    logic [IDX_W-1:0]     rd_idx_r, rd_load_idx_s, ar_idx_s;
    logic [7:0]           rd_len_r, rd_beat_r, rd_load_beat_s, rd_load_len_s, rd_next_beat_s;
    logic [3:0]           lat_cnt_r;
    logic                 rd_pend_r, arready_r, rvalid_r, rlast_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                 rd_load_s, rd_stall_s, ar_hs_s, r_hs_s;

    assign ar_hs_s        = s_axi_arvalid && arready_r;
    assign r_hs_s         = rvalid_r && s_axi_rready;
    assign ar_idx_s       = s_axi_araddr[OFF_W +: IDX_W];
    assign rd_next_beat_s = rd_beat_r + 8'd1;

    // Read FSM next state and the decision to load a beat this edge.
    always_comb begin
        r_state_nxt_s  = r_state_r;
        rd_load_s      = 1'b0;
        rd_stall_s     = 1'b0;
        rd_load_idx_s  = rd_idx_r;
        rd_load_beat_s = rd_beat_r;
        rd_load_len_s  = rd_len_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    if (LOAD_ON_AR) begin
                        rd_load_s      = 1'b1;
                        rd_load_idx_s  = ar_idx_s;
                        rd_load_beat_s = 8'd0;
                        rd_load_len_s  = s_axi_arlen;
                        r_state_nxt_s  = R_DATA;
                    end else begin
                        r_state_nxt_s = R_WAIT;
                    end
                end else begin
                    r_state_nxt_s = R_IDLE;
                end
            end
            R_WAIT: begin
                if (lat_cnt_r == 4'd0) begin
                    rd_load_s      = 1'b1;
                    rd_load_beat_s = 8'd0;
                    r_state_nxt_s  = R_DATA;
                end else begin
                    r_state_nxt_s = R_WAIT;
                end
            end
            R_DATA: begin
                if (r_hs_s) begin
                    if (rlast_r) begin
                        r_state_nxt_s = R_IDLE;
                    end else if (beat_stalled(stall_mask_i, rd_next_beat_s)) begin
                        rd_stall_s    = 1'b1;
                        r_state_nxt_s = R_DATA;
                    end else begin
                        rd_load_s      = 1'b1;
                        rd_load_beat_s = rd_next_beat_s;
                        r_state_nxt_s  = R_DATA;
                    end
                end else if (rd_pend_r) begin
                    rd_load_s     = 1'b1;
                    r_state_nxt_s = R_DATA;
                end else begin
                    r_state_nxt_s = R_DATA;
                end
            end
            default: begin
                r_state_nxt_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state, latency counter and registered R channel outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= '0;
            rd_idx_r  <= '0;
            rd_len_r  <= 8'd0;
            rd_beat_r <= 8'd0;
            lat_cnt_r <= 4'd0;
            rd_pend_r <= 1'b0;
        end else begin
            r_state_r <= r_state_nxt_s;
            arready_r <= (r_state_nxt_s == R_IDLE);
            if (ar_hs_s) begin
                rd_idx_r  <= ar_idx_s;
                rd_len_r  <= s_axi_arlen;
                lat_cnt_r <= LAT_INIT;
            end else if ((r_state_r == R_WAIT) && (lat_cnt_r != 4'd0)) begin
                lat_cnt_r <= lat_cnt_r - 4'd1;
            end
            if (rd_load_s) begin
                // Memory sampled here: a same-edge write is not yet visible.
                rdata_r   <= mem_r[rd_load_idx_s];
                rvalid_r  <= 1'b1;
                rlast_r   <= (rd_load_beat_s == rd_load_len_s);
                rd_idx_r  <= rd_load_idx_s + IDX_W'(1);
                rd_beat_r <= rd_load_beat_s;
                rd_pend_r <= 1'b0;
            end else if (r_hs_s) begin
                rvalid_r  <= 1'b0;
                rlast_r   <= 1'b0;
                rd_pend_r <= rd_stall_s;
                rd_beat_r <= rd_next_beat_s;
            end
        end
    end

    logic unused_addr_s;
    assign unused_addr_s = ^{s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rlast   = rlast_r;
    assign proto_err_o   = proto_err_r;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Self-checking bench for axi_burst_mem_slave: table of single-word strobe
// vectors, hand sequences for burst/stall/protocol/reset corners, and random
// bursts checked against a word-array reference model.
module tb_axi_burst_mem_slave;

    localparam int DEPTH  = 256;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = 32'd0, araddr = 32'd0, wdata = 32'd0;
    logic [7:0]  awlen = 8'd0, arlen = 8'd0, stall_mask = 8'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        awready, wready, bvalid, arready, rvalid, rlast, proto_err;
    logic [31:0] rdata;

    axi_burst_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
        .RD_LATENCY(RD_LAT), .STALL_EN(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awlen(awlen), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arlen(arlen), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .s_axi_rdata(rdata), .s_axi_rlast(rlast),
        .stall_mask_i(stall_mask), .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] model_mem [DEPTH];
    logic        model_err = 1'b0;
    logic [31:0] wdat_q [256];
    logic [3:0]  wstb_q [256];
    logic [31:0] rd_cap [256];

    typedef struct {
        logic [31:0] wr_addr;
        logic [31:0] init;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rd_addr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    // Write burst of len+1 beats (fewer if wlast comes early at beat last_at).
    task automatic do_write(input logic [31:0] addr, input int len, input int last_at,
                            input int bdelay, output int bubbles);
        int t;
        int exp_bub;
        int nbeats;
        int w;
        nbeats  = ((last_at < len) ? last_at : len) + 1;
        bubbles = 0;
        exp_bub = 0;
        @(negedge clk);
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
        t = 0;
        while (!awready && t < 100) begin @(negedge clk); t++; end
        check("aw_timeout", 32'(t < 100), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wvalid = 1'b1; wdata = wdat_q[b]; wstrb = wstb_q[b]; wlast = (b == last_at);
            if (stall_mask[b % 8]) exp_bub++;
            t = 0;
            while (!wready && t < 100) begin @(negedge clk); t++; end
            bubbles += t;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("w_bubbles", 32'(bubbles), 32'(exp_bub));
        for (int b = 0; b < nbeats; b++) begin
            w = (word_of(addr) + b) % DEPTH;
            for (int by = 0; by < 4; by++)
                if (wstb_q[b][by]) model_mem[w][8*by +: 8] = wdat_q[b][8*by +: 8];
        end
        if (last_at != len) model_err = 1'b1;
        for (int d = 0; d < bdelay; d++) begin
            check("bvalid_hold", 32'(bvalid), 32'd1);
            @(negedge clk);
        end
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        check("b_timeout", 32'(t < 100), 32'd1);
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'd0);
        check("proto_err", 32'(proto_err), 32'(model_err));
        check("awready_back", 32'(awready), 32'd1);
    endtask

    // Read burst, checking latency, stall gaps, data, rlast and hold stability.
    task automatic do_read(input logic [31:0] addr, input int len, input bit rand_rdy);
        int t;
        int lat;
        int gap;
        int hold;
        logic [31:0] exp;
        @(negedge clk);
        arvalid = 1'b1; araddr = addr; arlen = 8'(len);
        t = 0;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        check("ar_timeout", 32'(t < 100), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 100) begin @(negedge clk); lat++; end
        check("rd_latency", 32'(lat), 32'(RD_LAT));
        for (int b = 0; b <= len; b++) begin
            if (b > 0) begin
                gap = 0;
                while (!rvalid && gap < 100) begin @(negedge clk); gap++; end
                check("r_gap", 32'(gap), 32'(stall_mask[b % 8]));
            end
            exp = model_mem[(word_of(addr) + b) % DEPTH];
            rd_cap[b] = rdata;
            check("rdata", rdata, exp);
            check("rlast", 32'(rlast), 32'(b == len));
            hold = 0;
            while (rand_rdy && hold < 6 && $urandom_range(0, 2) == 0) begin
                rready = 1'b0;
                @(negedge clk);
                hold++;
                check("r_hold_valid", 32'(rvalid), 32'd1);
                check("r_hold_data", rdata, exp);
            end
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
        end
        check("rvalid_end", 32'(rvalid), 32'd0);
        check("arready_end", 32'(arready), 32'd1);
    endtask

    initial begin
        int bub;
        int t;
        logic [31:0] a;
        vecs[0] = '{32'h10,  32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 32'h10,  32'hDEAD_BEEF};
        vecs[1] = '{32'h0,   32'h1122_3344, 32'hAABB_CCDD, 4'h5, 32'h0,   32'h11BB_33DD};
        vecs[2] = '{32'h4,   32'h1122_3344, 32'hAABB_CCDD, 4'h4, 32'h4,   32'h11BB_3344};
        vecs[3] = '{32'h8,   32'h1122_3344, 32'hAABB_CCDD, 4'hA, 32'h8,   32'hAA22_CC44};
        vecs[4] = '{32'hC,   32'hCAFE_F00D, 32'h1234_5678, 4'h0, 32'hC,   32'hCAFE_F00D};
        vecs[5] = '{32'h23,  32'h0000_0000, 32'h55AA_55AA, 4'h3, 32'h20,  32'h0000_55AA};
        vecs[6] = '{32'h404, 32'h0102_0304, 32'hFFFF_FFFF, 4'h8, 32'h4,   32'hFF02_0304};
        vecs[7] = '{32'h3FC, 32'h0000_0000, 32'h8765_4321, 4'hF, 32'h3FC, 32'h8765_4321};

        // Reset state
        #3;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_proto", 32'(proto_err), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);

        // Fill the whole memory with one 256-beat burst (awlen=255)
        for (int i = 0; i < 256; i++) begin
            wdat_q[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
            wstb_q[i] = 4'hF;
        end
        do_write(32'h0, 255, 255, 0, bub);

        // Table-driven single-word strobe vectors
        for (int i = 0; i < 8; i++) begin
            wdat_q[0] = vecs[i].init;  wstb_q[0] = 4'hF;
            do_write(vecs[i].wr_addr, 0, 0, 0, bub);
            wdat_q[0] = vecs[i].wdata; wstb_q[0] = vecs[i].wstrb;
            do_write(vecs[i].wr_addr, 0, 0, (i == 1) ? 3 : 0, bub);
            do_read(vecs[i].rd_addr, 0, 1'b0);
            check("vec_rdata", rd_cap[0], vecs[i].exp);
        end

        // 16-beat write/read, rready tied high, no stalls
        for (int i = 0; i < 16; i++) begin wdat_q[i] = 32'(i); wstb_q[i] = 4'hF; end
        do_write(32'h100, 15, 15, 0, bub);
        do_read(32'h100, 15, 1'b0);
        for (int i = 0; i < 16; i++) check("t2_data", rd_cap[i], 32'(i));

        // Wrap with stall bubbles on beats 1 and 3
        stall_mask = 8'h0A;
        for (int i = 0; i < 4; i++) begin wdat_q[i] = 32'hC0DE_0000 + 32'(i); wstb_q[i] = 4'hF; end
        do_write(32'((DEPTH - 2) * 4), 3, 3, 0, bub);
        check("t5_bubbles", 32'(bub), 32'd2);
        do_read(32'((DEPTH - 2) * 4), 3, 1'b0);
        check("t5_word0", rd_cap[2], 32'hC0DE_0002);
        check("t5_word1", rd_cap[3], 32'hC0DE_0003);
        stall_mask = 8'h00;

        // Early wlast sets the sticky error; a clean burst leaves it set
        for (int i = 0; i < 4; i++) begin wdat_q[i] = 32'hBAD0_0000 + 32'(i); wstb_q[i] = 4'hF; end
        do_write(32'h300, 3, 1, 1, bub);
        do_write(32'h310, 0, 0, 0, bub);
        do_read(32'h300, 3, 1'b0);
        @(negedge clk); rstn = 1'b0;
        @(negedge clk);
        check("err_cleared", 32'(proto_err), 32'd0);
        rstn = 1'b1; model_err = 1'b0;
        // Missing wlast on the final beat also flags the error
        do_write(32'h320, 2, 3, 0, bub);

        // Random bursts with random stall patterns and backpressure
        for (int it = 0; it < 20; it++) begin
            int len;
            stall_mask = 8'($urandom);
            a = 32'($urandom_range(0, 4095));
            len = $urandom_range(0, 15);
            for (int i = 0; i <= len; i++) begin wdat_q[i] = $urandom; wstb_q[i] = 4'($urandom); end
            do_write(a, len, len, $urandom_range(0, 3), bub);
            if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 4095));
            do_read(a, $urandom_range(0, 15), 1'b1);
        end
        stall_mask = 8'h00;

        // Async reset during beat 5 of an 8-beat read
        @(negedge clk);
        arvalid = 1'b1; araddr = 32'h200; arlen = 8'd7;
        t = 0;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            t = 0;
            while (!rvalid && t < 100) begin @(negedge clk); t++; end
            rready = 1'b1;
            @(negedge clk);
        end
        rready = 1'b0;
        check("t6_beat5_valid", 32'(rvalid), 32'd1);
        check("t6_beat5_data", rdata, model_mem[word_of(32'h200) + 5]);
        #2 rstn = 1'b0;
        #1;
        check("t6_rvalid", 32'(rvalid), 32'd0);
        check("t6_arready", 32'(arready), 32'd0);
        check("t6_proto", 32'(proto_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1; model_err = 1'b0;
        @(negedge clk);
        check("t6_arready_rel", 32'(arready), 32'd1);
        check("t6_rvalid_rel", 32'(rvalid), 32'd0);
        do_read(32'h200, 7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
